// File: rtl/sha256_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha256_pkg: encodings, rotate/shift tables and FSM states for the  |
// | serial SHA-256 sigma sequencer.                      Rev 1.0       |
// +--------------------------------------------------------------------+
package sha256_pkg;

  localparam int WORD_W = 32;
  localparam int AMT_W  = 5;

  typedef logic [1:0] func_t;

  localparam func_t FUNC_BSIG0 = 2'd0;
  localparam func_t FUNC_BSIG1 = 2'd1;
  localparam func_t FUNC_SSIG0 = 2'd2;
  localparam func_t FUNC_SSIG1 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STEP0 = 3'd1,
    ST_STEP1 = 3'd2,
    ST_STEP2 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Row = function select, column = step; the leftmost entry is [0][0].
  localparam logic [0:3][0:2][AMT_W-1:0] ROT_AMT = {
    5'd2,  5'd13, 5'd22,
    5'd6,  5'd11, 5'd25,
    5'd7,  5'd18, 5'd3,
    5'd17, 5'd19, 5'd10
  };

  localparam logic [0:3][0:2] SHR_FLAG = {3'b000, 3'b000, 3'b001, 3'b001};

  function automatic logic [1:0] step_of(input state_t st);
    case (st)
      ST_STEP1: step_of = 2'd1;
      ST_STEP2: step_of = 2'd2;
      default:  step_of = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_sigma_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha256_sigma_sequencer_if: request/response handshake bundle.      |
// |                                                      Rev 1.0       |
// +--------------------------------------------------------------------+
interface sha256_sigma_sequencer_if;
  import sha256_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  func_t             in_func;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              busy;

  modport master (
    output in_valid, in_data, in_func, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_func, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/right_rotator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | right_rotator: combinational rotate-right by a variable amount.    |
// |                                                      Rev 1.0       |
// +--------------------------------------------------------------------+
module right_rotator #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] data_out
);
  localparam logic [AMT_W:0] FULL_W = (AMT_W + 1)'(WIDTH);

  // A zero amount shifts left by WIDTH, which yields 0 and leaves data_in intact.
  assign data_out = (data_in >> amt) | (data_in << (FULL_W - {1'b0, amt}));
endmodule
`default_nettype wire

// File: rtl/sha256_sigma_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha256_sigma_sequencer: computes one SHA-256 sigma function over   |
// | three cycles through a single shared rotator.        Rev 1.0       |
// +--------------------------------------------------------------------+
module sha256_sigma_sequencer
  import sha256_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  sha256_sigma_sequencer_if.slave  bus
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] x_q, x_d;
  func_t             func_q, func_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [1:0]        step;
  logic [AMT_W-1:0]  amt;
  logic              shr;
  logic [WORD_W-1:0] rot_out;
  logic [WORD_W-1:0] term;

  assign step = step_of(state_q);
  assign amt  = ROT_AMT[func_q][step];
  assign shr  = SHR_FLAG[func_q][step];

  right_rotator #(.WIDTH(WORD_W), .AMT_W(AMT_W)) u_rot (
    .data_in  (x_q),
    .amt      (amt),
    .data_out (rot_out)
  );

  // Masking off the wrapped-around bits turns the rotate into a logical shift.
  assign term = shr ? (rot_out & ({WORD_W{1'b1}} >> amt)) : rot_out;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    func_d     = func_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d     = bus.in_data;
          func_d  = bus.in_func;
          acc_d   = '0;
          state_d = ST_STEP0;
        end
      end
      ST_STEP0: begin
        acc_d   = acc_q ^ term;
        state_d = ST_STEP1;
      end
      ST_STEP1: begin
        acc_d   = acc_q ^ term;
        state_d = ST_STEP2;
      end
      ST_STEP2: begin
        acc_d      = acc_q ^ term;
        out_data_d = acc_q ^ term;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      func_q      <= FUNC_BSIG0;
      acc_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      func_q      <= func_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire
